sseg_capture_decoder: RTL

Receive side of the seven-segment display interface. The block samples a multiplexed, active-low segment bus and its one-hot digit strobes, and decodes each segment pattern back to its hex nibble. It accepts a multi-digit value only after the same pattern set has been seen for a parameterised number of consecutive scan frames. It sits between an external or board-level display tap and the on-chip self-check/readback logic, and inverts the hex-to-segment encoding used by the display path.

---
 rtl/sseg_pkg.sv | 58 +++++
 rtl/sseg_sync2.sv | 29 ++
 rtl/sseg_capture_decoder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared seven-segment definitions.
//   - SEG_0..SEG_F, SEG_BLANK : active-low segment patterns, bit 6 = g .. bit 0 = a
//   - frame_state_t           : frame collection FSM states
//   - seg_to_nibble()         : pattern -> {illegal, blank, nibble}
// The transmit-side encoder uses the same constants, so both directions of the
// map come from one place.
package sseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EVAL    = 1'b1
  } frame_state_t;

  // Returns {illegal, blank, nibble}. Blank and illegal patterns report nibble 0.
  function automatic logic [5:0] seg_to_nibble(input logic [6:0] seg);
    logic [5:0] res;
    case (seg)
      SEG_0:     res = 6'h00;
      SEG_1:     res = 6'h01;
      SEG_2:     res = 6'h02;
      SEG_3:     res = 6'h03;
      SEG_4:     res = 6'h04;
      SEG_5:     res = 6'h05;
      SEG_6:     res = 6'h06;
      SEG_7:     res = 6'h07;
      SEG_8:     res = 6'h08;
      SEG_9:     res = 6'h09;
      SEG_A:     res = 6'h0A;
      SEG_B:     res = 6'h0B;
      SEG_C:     res = 6'h0C;
      SEG_D:     res = 6'h0D;
      SEG_E:     res = 6'h0E;
      SEG_F:     res = 6'h0F;
      SEG_BLANK: res = 6'b01_0000;
      default:   res = 6'b10_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sseg_sync2.sv
// sseg_sync2: parameterised-width two-flop synchroniser.
//   clk, reset : destination clock, asynchronous active-high reset
//   d          : asynchronous input bus
//   q          : synchronised output bus (RESET_VAL while in reset)
// Bits are synchronised independently; the consumer must tolerate skew
// between bits (the decoder's settle check handles this).
module sseg_sync2 #(
  parameter int                WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sseg_capture_decoder.sv
// sseg_capture_decoder: receive side of the multiplexed seven-segment bus.
//   clk, reset   : system clock, asynchronous active-high reset
//   segs_in      : active-low segment bus (g..a), asynchronous
//   digit_sel    : one-hot digit strobes, asynchronous
//   value        : published hex value, digit 0 in [3:0]
//   blank        : per-digit all-off flag (matching nibble reads 0)
//   value_valid  : one-cycle pulse when value/blank are updated
//   pattern_err  : one-cycle pulse when a frame with an illegal pattern is dropped
// A frame is one sample of every digit. A value is published only after the
// same frame has been seen STABLE_FRAMES times in a row.
module sseg_capture_decoder
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_FRAMES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              segs_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    value_valid,
  output logic                    pattern_err
);

  localparam int             CNT_W   = $clog2(STABLE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------------------------------------------------------- sync
  logic [6:0]            segs_sync;
  logic [NUM_DIGITS-1:0] sel_sync;

  sseg_sync2 #(.WIDTH(7), .RESET_VAL(SEG_BLANK)) u_sync_segs (
    .clk   (clk),
    .reset (reset),
    .d     (segs_in),
    .q     (segs_sync)
  );

  sseg_sync2 #(.WIDTH(NUM_DIGITS), .RESET_VAL('0)) u_sync_sel (
    .clk   (clk),
    .reset (reset),
    .d     (digit_sel),
    .q     (sel_sync)
  );

  // ---------------------------------------------------------------- settle
  // A strobe qualifies once it is one-hot and unchanged for a cycle, which
  // also masks inter-bit skew from the synchroniser. qual_prev makes each
  // strobe assertion sample only on its first qualified cycle.
  logic [NUM_DIGITS-1:0] sel_prev;
  logic                  qual_prev;
  logic                  qualified;
  logic                  sample;
  logic [NUM_DIGITS-1:0] sample_mask;
  logic [5:0]            decoded;

  assign qualified   = $onehot(sel_sync) && (sel_sync == sel_prev);
  assign sample      = qualified && !qual_prev;
  assign sample_mask = sample ? sel_sync : '0;
  assign decoded     = seg_to_nibble(segs_sync);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_prev  <= '0;
      qual_prev <= 1'b0;
    end else begin
      sel_prev  <= sel_sync;
      qual_prev <= qualified;
    end
  end

  // ---------------------------------------------------------------- slots
  logic [4*NUM_DIGITS-1:0] slot_nib;
  logic [NUM_DIGITS-1:0]   slot_blank;
  logic [NUM_DIGITS-1:0]   slot_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_nib     <= '0;
      slot_blank   <= '0;
      slot_illegal <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sample_mask[i]) begin
          slot_nib[i*4 +: 4] <= decoded[3:0];
          slot_blank[i]      <= decoded[4];
          slot_illegal[i]    <= decoded[5];
        end
      end
    end
  end

  // ---------------------------------------------------------------- frame FSM
  frame_state_t            state;
  logic [NUM_DIGITS-1:0]   collected;
  logic [NUM_DIGITS-1:0]   collected_next;
  logic [4*NUM_DIGITS-1:0] prev_nib;
  logic [NUM_DIGITS-1:0]   prev_blank;
  logic [CNT_W-1:0]        stable_cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic                    published;
  logic                    frame_illegal;
  logic                    frame_same;
  logic                    frame_new;

  // In EVAL the old bits are dropped, but a sample landing in that cycle
  // already belongs to the next frame.
  always_comb begin
    collected_next = collected | sample_mask;
    if (state == ST_EVAL) begin
      collected_next = sample_mask;
    end
  end

  assign frame_illegal = |slot_illegal;
  assign frame_same    = (slot_nib == prev_nib) && (slot_blank == prev_blank);
  assign frame_new     = !published || (slot_nib != value) || (slot_blank != blank);

  always_comb begin
    cnt_next = CNT_ONE;
    if (frame_same) begin
      cnt_next = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_COLLECT;
      collected   <= '0;
      prev_nib    <= '0;
      prev_blank  <= '0;
      stable_cnt  <= '0;
      published   <= 1'b0;
      value       <= '0;
      blank       <= '0;
      value_valid <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      pattern_err <= 1'b0;
      collected   <= collected_next;
      case (state)
        ST_COLLECT: begin
          if (&(collected | sample_mask)) begin
            state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          state <= ST_COLLECT;
          if (frame_illegal) begin
            // Dropped frame: prev_nib/prev_blank keep the last good frame.
            pattern_err <= 1'b1;
            stable_cnt  <= '0;
          end else begin
            stable_cnt <= cnt_next;
            if (!frame_same) begin
              prev_nib   <= slot_nib;
              prev_blank <= slot_blank;
            end
            if ((cnt_next == CNT_MAX) && frame_new) begin
              value       <= slot_nib;
              blank       <= slot_blank;
              published   <= 1'b1;
              value_valid <= 1'b1;
            end
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule
